// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of a single-port
// synchronous memory. Accepts one request in IDLE and issues exactly one
// memory cycle. It waits out the read latency, then pulses ACK to the winner.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN selects fixed priority
// (requester 0 wins ties) instead of the default round-robin.
module mem_arbiter #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 16,
    parameter int unsigned READ_LAT = 1
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic [1:0]      REQ,
    input  logic [1:0]      WE,
    input  logic [2*AW-1:0] ADDR,
    input  logic [2*DW-1:0] WDATA,
    output logic [1:0]      ACK,
    output logic [2*DW-1:0] RDATA,
    output logic [1:0]      GRANT,
    output logic            BUSY,
    output logic            MEM_WE,
    output logic [AW-1:0]   MEM_ADDR,
    output logic [DW-1:0]   MEM_DIN,
    input  logic [DW-1:0]   MEM_DOUT
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_din_q, mem_din_d;
    logic [2*DW-1:0]   rdata_q, rdata_d;
    logic              win_sel;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Requester 0 (CPU) always wins when it is requesting.
    always_comb begin
        win_sel = ~REQ[0];
    end
`else
    logic              last_q, last_d;

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        win_sel = (REQ == 2'b11) ? ~last_q : REQ[1];
    end
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        ack_d      = 2'b00;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rdata_d    = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (REQ != 2'b00) begin
                    win_d      = win_sel;
                    we_d       = WE[win_sel];
                    mem_we_d   = WE[win_sel];
                    mem_addr_d = win_sel ? ADDR[2*AW-1:AW] : ADDR[AW-1:0];
                    mem_din_d  = win_sel ? WDATA[2*DW-1:DW] : WDATA[DW-1:0];
                    grant_d    = win_sel ? 2'b10 : 2'b01;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d     = win_sel;
`endif
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    ack_d   = grant_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(READ_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == CNT_W'(0)) begin
                    if (win_q) begin
                        rdata_d[2*DW-1:DW] = MEM_DOUT;
                    end else begin
                        rdata_d[DW-1:0] = MEM_DOUT;
                    end
                    ack_d   = grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rdata_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rdata_q    <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign ACK      = ack_q;
    assign RDATA    = rdata_q;
    assign GRANT    = grant_q;
    assign BUSY     = busy_q;
    assign MEM_WE   = mem_we_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DIN  = mem_din_q;

endmodule
